mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Parametrised successor to the two-port I/D cache controller.
- Arbitrates NUM_CH cache-side requesters (I-cache, D-cache, and future DMA or second-core ports) onto one shared pipelined main memory.
- Read requests perform block fills of BLOCK_WORDS sequential words. Write requests perform single-word write-through.
- Arbitration is fixed-priority or round-robin, selected by parameter.

Parameters:
- NUM_CH, 2: number of requester channels (>=1).
- ADDR_W, 16: byte-address width.
- DATA_W, 16: word width; words are 2 bytes apart.
- BLOCK_WORDS, 8: words per read fill; power of 2, >=2.
- PRIO_MODE, 0: 0 = fixed priority, lowest index wins; 1 = round-robin.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_CH  per-channel request.
- wr  in  NUM_CH  per-channel: 1 = write, 0 = block read.
- addr  in  NUM_CH*ADDR_W  per-channel byte address; channel i occupies slice [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_CH*DATA_W  per-channel write data.
- grant  out  NUM_CH  one-hot; marks the channel that owns memory.
- rvalid  out  NUM_CH  one-hot; fill word valid for the granted channel.
- rdata  out  DATA_W  fill word, shared by all channels.
- rword  out  clog2(BLOCK_WORDS)  index of the current fill word within the block.
- done  out  NUM_CH  one-cycle completion pulse.
- busy  out  1  high when the FSM is not in IDLE.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_data_valid  in  1  memory read data valid; arrives a fixed latency after each enabled read.

Behaviour:
- FSM states: IDLE, READ, DRAIN, WRITE.
- Reset (async, rst_n=0):
  - state=IDLE; grant, done, rvalid, mem_enable, mem_wr all 0.
  - mem_addr, mem_wdata, rword, all counters 0.
  - Round-robin pointer set to NUM_CH-1, so channel 0 is considered first.
- IDLE:
  - If any req is high at a clock edge, the winner is registered into grant, and state moves to READ (wr=0) or WRITE (wr=1).
  - grant is visible the cycle after req is sampled.
  - Fixed mode: lowest set index wins.
  - RR mode: search starts at pointer+1 modulo NUM_CH; pointer is updated to the winner on grant.
- grant is held constant until the done cycle inclusive, then cleared.
- After done, at least one cycle of IDLE follows with grant=0. Back-to-back grants are therefore separated by a one-cycle bubble.
- READ:
  - base = addr[g] with the low log2(BLOCK_WORDS)+1 bits cleared.
  - Issue counter k runs 0..BLOCK_WORDS-1, one per cycle, with mem_enable=1, mem_wr=0, mem_addr=base+2k.
  - After k=BLOCK_WORDS-1 is issued, state moves to DRAIN.
- READ and DRAIN, returned data:
  - Each mem_data_valid drives rvalid[g]=1, rdata=mem_rdata (combinational pass-through), and rword = return count.
  - The return count increments on each valid.
  - On the BLOCK_WORDS-th valid, done[g] pulses in the same cycle and the next state is IDLE.
  - Valid may arrive while still in READ; both counters are independent.
- WRITE:
  - Lasts exactly one cycle: mem_enable=1, mem_wr=1, mem_addr=addr[g] (unaligned is passed as given), mem_wdata=wdata[g].
  - done[g] pulses in the same cycle; next state is IDLE.
- mem_enable=0 in IDLE and DRAIN.
- mem_data_valid is ignored in IDLE and WRITE: no rvalid is produced and no counter moves. Stale data after a reset is therefore dropped.
- Address and data sampling: the requester must hold addr and wdata stable while granted. The block samples addr[g] combinationally every issue cycle; it does not latch.
- Request dropped mid-operation: the transaction runs to completion (memory cannot abort), and done is still pulsed.
- Reset mid-operation: immediate return to the reset state. No done is produced for the aborted transaction.
- Simultaneous req from several channels: exactly one grant; others wait, keeping req high.
- NUM_CH=1: the arbiter degenerates to a pass-through FSM; the RR pointer is constant 0.

Test Plan:
- Reset: hold rst_n=0 mid-clock -> all outputs 0 immediately, without waiting for a clock edge; busy=0.
- Single read, NUM_CH=2, BLOCK_WORDS=8, memory latency 4, ch1 addr=0x1236:
  - grant=2'b10 one cycle after req.
  - mem_addr=0x1230,0x1232,…,0x123E on 8 consecutive cycles.
  - rvalid[1] on 8 cycles starting 4 after the first issue, with rword 0..7.
  - done[1] coincides with rword=7; grant clears the next cycle.
- Fixed priority, PRIO_MODE=0: ch0 read and ch1 write (addr=0x0040, wdata=0xBEEF) requested in the same cycle:
  - ch0 fill completes first.
  - One bubble cycle follows.
  - Then a single cycle with mem_wr=1, mem_addr=0x0040, mem_wdata=0xBEEF, done[1]=1.
- Round-robin, PRIO_MODE=1, NUM_CH=3: all channels hold req with wr=1 continuously -> grant sequence 001,010,100,001, with one bubble between each.
- Reset during fill: assert rst_n=0 after 3 words returned, release it, then let the memory deliver the remaining valids -> no rvalid and no done. A following ch0 read completes normally with rword 0..7.
- Request dropped: deassert req[0] two cycles into a read -> all 8 addresses are still issued, all 8 rvalid[0] occur, and done[0] pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory among NUM_CH cache-side
// requesters. Reads fetch a full aligned block of BLOCK_WORDS words and
// writes are single-word write-through. Arbitration is either fixed
// priority (lowest index wins) or round-robin.
module mem_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int PRIO_MODE   = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH-1:0]          wr,
    input  logic [NUM_CH*ADDR_W-1:0]   addr,
    input  logic [NUM_CH*DATA_W-1:0]   wdata,
    output logic [NUM_CH-1:0]          grant,
    output logic [NUM_CH-1:0]          rvalid,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(BLOCK_WORDS)-1:0] rword,
    output logic [NUM_CH-1:0]          done,
    output logic                       busy,
    output logic                       mem_enable,
    output logic                       mem_wr,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    input  logic                       mem_data_valid
);

    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WIDX = $clog2(BLOCK_WORDS);
    localparam logic [WIDX-1:0]   LAST_WORD = WIDX'(BLOCK_WORDS - 1);
    // Clears the word index and the byte-within-word bit: block alignment.
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((2 ** (WIDX + 1)) - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

    state_t            state_q;
    logic [NUM_CH-1:0] grant_q;
    logic [CHW-1:0]    gIdx_q;
    logic [CHW-1:0]    rrPtr_q;
    logic [WIDX-1:0]   issueCnt_q;
    logic [WIDX-1:0]   retCnt_q;

    int                rrStart;
    int                cand;
    logic [CHW-1:0]    candIdx;
    logic              winFound;
    logic [CHW-1:0]    winIdx;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              fillValid;

    assign rrStart  = (PRIO_MODE == 1) ? int'(rrPtr_q) + 1 : 0;
    assign selAddr  = addr[int'(gIdx_q) * ADDR_W +: ADDR_W];
    assign selWdata = wdata[int'(gIdx_q) * DATA_W +: DATA_W];
    assign fillValid = mem_data_valid && ((state_q == READ) || (state_q == DRAIN));
    assign grant    = grant_q;
    assign busy     = (state_q != IDLE);

    // Pick the winning requester, scanning from the rotating start point.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        cand     = 0;
        candIdx  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand    = (rrStart + i) % NUM_CH;
            candIdx = CHW'(cand);
            if (!winFound && req[candIdx]) begin
                winFound = 1'b1;
                winIdx   = candIdx;
            end
        end
    end

    // Main controller: owner selection, issue counter and return counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gIdx_q     <= '0;
            rrPtr_q    <= CHW'(NUM_CH - 1);
            issueCnt_q <= '0;
            retCnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winFound) begin
                        grant_q    <= NUM_CH'(1) << winIdx;
                        gIdx_q     <= winIdx;
                        rrPtr_q    <= winIdx;
                        issueCnt_q <= '0;
                        retCnt_q   <= '0;
                        state_q    <= wr[winIdx] ? WRITE : READ;
                    end
                end
                READ, DRAIN: begin
                    if (state_q == READ) begin
                        issueCnt_q <= issueCnt_q + 1'b1;
                        if (issueCnt_q == LAST_WORD) begin
                            state_q <= DRAIN;
                        end
                    end
                    if (mem_data_valid) begin
                        retCnt_q <= retCnt_q + 1'b1;
                        if (retCnt_q == LAST_WORD) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                        end
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    // Memory strobes and fill-return signalling for the current owner.
    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rvalid     = '0;
        rdata      = '0;
        rword      = '0;
        done       = '0;
        if (state_q == READ) begin
            mem_enable = 1'b1;
            mem_addr   = (selAddr & BASE_MASK) | ADDR_W'({issueCnt_q, 1'b0});
        end
        if (state_q == WRITE) begin
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = selAddr;
            mem_wdata  = selWdata;
            done       = grant_q;
        end
        if (fillValid) begin
            rvalid = grant_q;
            rdata  = mem_rdata;
            rword  = retCnt_q;
            if (retCnt_q == LAST_WORD) begin
                done = grant_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter. One instance uses two
// channels with fixed priority behind a latency-4 memory model; a second
// uses three channels in round-robin mode for the rotation sequence.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;

    // Two-channel fixed-priority instance.
    logic [1:0]  req = '0;
    logic [1:0]  wr = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  grant, rvalid, done;
    logic [15:0] rdata;
    logic [2:0]  rword;
    logic        busy, memEnable, memWr;
    logic [15:0] memAddr, memWdata, memRdata;
    logic        memDataValid;

    // Three-channel round-robin instance.
    logic [2:0]  rrReq = '0;
    logic [2:0]  rrWr = '0;
    logic [47:0] rrAddr = '0;
    logic [47:0] rrWdata = '0;
    logic [2:0]  rrGrant, rrRvalid, rrDone;
    logic [15:0] rrRdata;
    logic [2:0]  rrRword;
    logic        rrBusy, rrMemEnable, rrMemWr;
    logic [15:0] rrMemAddr, rrMemWdata;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8), .PRIO_MODE(0)) dut (
        .clk(clk), .rst_n(rstN), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
        .grant(grant), .rvalid(rvalid), .rdata(rdata), .rword(rword), .done(done),
        .busy(busy), .mem_enable(memEnable), .mem_wr(memWr), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_rdata(memRdata), .mem_data_valid(memDataValid)
    );

    mem_arbiter #(.NUM_CH(3), .ADDR_W(16), .DATA_W(16), .BLOCK_WORDS(8), .PRIO_MODE(1)) dutRr (
        .clk(clk), .rst_n(rstN), .req(rrReq), .wr(rrWr), .addr(rrAddr), .wdata(rrWdata),
        .grant(rrGrant), .rvalid(rrRvalid), .rdata(rrRdata), .rword(rrRword), .done(rrDone),
        .busy(rrBusy), .mem_enable(rrMemEnable), .mem_wr(rrMemWr), .mem_addr(rrMemAddr),
        .mem_wdata(rrMemWdata), .mem_rdata(16'h0000), .mem_data_valid(1'b0)
    );

    always #5 clk = ~clk;

    // Latency-4 read pipeline; deliberately unaffected by reset so that
    // in-flight data keeps arriving after the arbiter is reset.
    logic [3:0]       pipeV = '0;
    logic [3:0][15:0] pipeA = '0;
    always @(posedge clk) begin
        pipeV <= {pipeV[2:0], memEnable && !memWr};
        pipeA <= {pipeA[2:0], memAddr};
    end
    assign memDataValid = pipeV[3];
    assign memRdata     = pipeA[3] ^ 16'hA5A5;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic r, input logic w,
                                 input logic [15:0] a, input logic [15:0] d);
        req[ch]            = r;
        wr[ch]             = w;
        addr[ch*16 +: 16]  = a;
        wdata[ch*16 +: 16] = d;
    endtask

    // Full block read on one channel; the requester drops req at cycle dropAt.
    task automatic readBlock(input int ch, input logic [15:0] a, input int dropAt);
        logic [15:0] base;
        logic [1:0]  oneHot;
        base   = a & 16'hFFF0;
        oneHot = 2'(1 << ch);
        @(negedge clk);
        applyStimulus(ch, 1'b1, 1'b0, a, 16'h0000);
        for (int t = 1; t <= 13; t++) begin
            @(negedge clk);
            checkOutput($sformatf("rd%0d t%0d grant", ch, t), 32'(grant), (t <= 12) ? 32'(oneHot) : 32'd0);
            checkOutput($sformatf("rd%0d t%0d enable", ch, t), 32'(memEnable), (t <= 8) ? 32'd1 : 32'd0);
            checkOutput($sformatf("rd%0d t%0d memWr", ch, t), 32'(memWr), 32'd0);
            if (t <= 8)
                checkOutput($sformatf("rd%0d t%0d memAddr", ch, t), 32'(memAddr), 32'(base + 16'(2 * (t - 1))));
            checkOutput($sformatf("rd%0d t%0d rvalid", ch, t), 32'(rvalid),
                        (t >= 5 && t <= 12) ? 32'(oneHot) : 32'd0);
            if (t >= 5 && t <= 12) begin
                checkOutput($sformatf("rd%0d t%0d rword", ch, t), 32'(rword), 32'(t - 5));
                checkOutput($sformatf("rd%0d t%0d rdata", ch, t), 32'(rdata),
                            32'((base + 16'(2 * (t - 5))) ^ 16'hA5A5));
            end
            checkOutput($sformatf("rd%0d t%0d done", ch, t), 32'(done), (t == 12) ? 32'(oneHot) : 32'd0);
            checkOutput($sformatf("rd%0d t%0d busy", ch, t), 32'(busy), (t <= 12) ? 32'd1 : 32'd0);
            if (t == dropAt) req[ch] = 1'b0;
        end
    endtask

    initial begin
        // Reset asserted from time zero, checked before any clock edge.
        #3;
        checkOutput("rst grant", 32'(grant), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst enable", 32'(memEnable), 32'd0);
        checkOutput("rst memAddr", 32'(memAddr), 32'd0);
        checkOutput("rst rrGrant", 32'(rrGrant), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("idle busy", 32'(busy), 32'd0);

        $display("[TB] single read ch1 0x1236");
        readBlock(1, 16'h1236, 1);

        $display("[TB] fixed priority ch0 read vs ch1 write");
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 16'h0100, 16'h0000);
        applyStimulus(1, 1'b1, 1'b1, 16'h0040, 16'hBEEF);
        for (int t = 1; t <= 15; t++) begin
            @(negedge clk);
            checkOutput($sformatf("fp t%0d grant", t), 32'(grant),
                        (t <= 12) ? 32'd1 : (t == 14) ? 32'd2 : 32'd0);
            checkOutput($sformatf("fp t%0d done", t), 32'(done),
                        (t == 12) ? 32'd1 : (t == 14) ? 32'd2 : 32'd0);
            checkOutput($sformatf("fp t%0d memWr", t), 32'(memWr), (t == 14) ? 32'd1 : 32'd0);
            if (t == 12) checkOutput("fp t12 rword", 32'(rword), 32'd7);
            if (t == 13) checkOutput("fp t13 busy", 32'(busy), 32'd0);
            if (t == 14) begin
                checkOutput("fp t14 enable", 32'(memEnable), 32'd1);
                checkOutput("fp t14 memAddr", 32'(memAddr), 32'h0040);
                checkOutput("fp t14 memWdata", 32'(memWdata), 32'hBEEF);
            end
            if (t == 1) req[0] = 1'b0;
            if (t == 14) req[1] = 1'b0;
        end

        $display("[TB] round robin three writers");
        @(negedge clk);
        rrReq = 3'b111;
        rrWr  = 3'b111;
        rrAddr = {16'h0300, 16'h0200, 16'h0100};
        rrWdata = {16'h3333, 16'h2222, 16'h1111};
        for (int t = 1; t <= 7; t++) begin
            logic [2:0] expG;
            expG = (t == 1 || t == 7) ? 3'b001 : (t == 3) ? 3'b010 : (t == 5) ? 3'b100 : 3'b000;
            @(negedge clk);
            checkOutput($sformatf("rr t%0d grant", t), 32'(rrGrant), 32'(expG));
            checkOutput($sformatf("rr t%0d done", t), 32'(rrDone), 32'(expG));
            checkOutput($sformatf("rr t%0d memWr", t), 32'(rrMemWr), (expG != 0) ? 32'd1 : 32'd0);
            if (t == 5) checkOutput("rr t5 memWdata", 32'(rrMemWdata), 32'h3333);
            if (t == 7) rrReq = 3'b000;
        end

        $display("[TB] reset during fill");
        @(negedge clk);
        applyStimulus(0, 1'b1, 1'b0, 16'h0200, 16'h0000);
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            if (t >= 5) begin
                checkOutput($sformatf("rf t%0d rvalid", t), 32'(rvalid), 32'd1);
                checkOutput($sformatf("rf t%0d rword", t), 32'(rword), 32'(t - 5));
            end
            if (t == 1) req[0] = 1'b0;
        end
        rstN = 1'b0;
        #1;
        checkOutput("rf async grant", 32'(grant), 32'd0);
        checkOutput("rf async busy", 32'(busy), 32'd0);
        checkOutput("rf async enable", 32'(memEnable), 32'd0);
        checkOutput("rf async rvalid", 32'(rvalid), 32'd0);
        checkOutput("rf async rword", 32'(rword), 32'd0);
        checkOutput("rf async memAddr", 32'(memAddr), 32'd0);
        for (int t = 8; t <= 13; t++) begin
            @(negedge clk);
            checkOutput($sformatf("rf t%0d rvalid", t), 32'(rvalid), 32'd0);
            checkOutput($sformatf("rf t%0d done", t), 32'(done), 32'd0);
            checkOutput($sformatf("rf t%0d grant", t), 32'(grant), 32'd0);
            if (t == 9) rstN = 1'b1;
        end
        readBlock(0, 16'h0300, 1);

        $display("[TB] request dropped mid read");
        readBlock(0, 16'h0456, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
